// File: rtl/aes_core_scheduler.sv
// Purpose : arbitrates the shared AES round datapath between the encrypt and decrypt cores.
// Latency : a request seen in IDLE produces the core start pulse on the next cycle; back-to-back jobs are at least 5 cycles apart.
// Backpressure: requests are level-held and sampled only in IDLE; nothing is issued while key_ready is low.
//
// Ports:
//   clk, n_rst               clock and asynchronous active-low reset
//   key_ready                round keys valid; gates new issues only, never aborts a job
//   enc_req / dec_req        level requests from the two requesters
//   enc_busy / dec_busy      busy flags from the two cores; only the selected one is observed
//   enable_encrypt/_decrypt  one-cycle start pulses
//   enc_grant / dec_grant    datapath ownership, ISSUE through DONE inclusive
//   enc_done / dec_done      one-cycle completion pulses
//   sched_busy               high whenever the scheduler is not in IDLE
//   timeout_err              one-cycle abort pulse (0 unless SCHED_TIMEOUT_EN)
//
// Optional feature: define SCHED_TIMEOUT_EN to enable the wait-state watchdog.
// With it, the scheduler spends at most TIMEOUT_CYCLES cycles in WAIT_START+WAIT_DONE
// and timeout_err is raised in the first IDLE cycle after the abort.
// Without it, the wait states wait indefinitely.

module aes_core_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic n_rst,
  input  logic key_ready,
  input  logic enc_req,
  input  logic dec_req,
  input  logic enc_busy,
  input  logic dec_busy,
  output logic enable_encrypt,
  output logic enable_decrypt,
  output logic enc_grant,
  output logic dec_grant,
  output logic enc_done,
  output logic dec_done,
  output logic sched_busy,
  output logic timeout_err
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   sel_q, sel_d;    // 0 = encrypt, 1 = decrypt
  logic   last_q, last_d;  // path granted most recently
  logic   sel_busy;
  logic   abort;
  logic   in_wait;

  // The non-selected core's busy is never looked at.
  assign sel_busy = sel_q ? dec_busy : enc_busy;
  assign in_wait  = (state_q == WAIT_START) || (state_q == WAIT_DONE);

`ifdef SCHED_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] cnt_q, cnt_d;
  logic       tmo_q;

  // cnt_q holds the number of wait cycles already completed, so the abort
  // fires on the wait cycle that brings the count up to TIMEOUT_CYCLES.
  assign abort = in_wait && (cnt_q == (TMO_LIMIT - 8'd1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE) begin
      cnt_d = 8'd0;
    end else if (in_wait) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= 8'd0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= abort;
    end
  end

  assign timeout_err = tmo_q;
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;  // encrypt wins the first tie after reset
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (key_ready && (enc_req || dec_req)) begin
          state_d = ISSUE;
          // Tie goes to the path opposite the previous grant.
          sel_d   = (enc_req && dec_req) ? ~last_q : dec_req;
        end
      end
      ISSUE: begin
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (abort) begin
          state_d = IDLE;
          last_d  = sel_q;
        end else if (sel_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (abort) begin
          state_d = IDLE;
          last_d  = sel_q;
        end else if (!sel_busy) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        last_d  = sel_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore decodes of registered state only.
  assign enable_encrypt = (state_q == ISSUE) && !sel_q;
  assign enable_decrypt = (state_q == ISSUE) &&  sel_q;
  assign enc_grant      = (state_q != IDLE)  && !sel_q;
  assign dec_grant      = (state_q != IDLE)  &&  sel_q;
  assign enc_done       = (state_q == DONE)  && !sel_q;
  assign dec_done       = (state_q == DONE)  &&  sel_q;
  assign sched_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_aes_core_scheduler.sv
// Purpose : scoreboard bench for aes_core_scheduler; stimulus pushes expected pulses, a negedge monitor pops and compares.
// Latency : expected pulse cycles are hand-derived from the stimulus timing.
// Backpressure: none; every wait is a fixed number of clock cycles.

module tb_aes_core_scheduler;

  localparam int K_EN_ENC = 0;
  localparam int K_EN_DEC = 1;
  localparam int K_ENC_DONE = 2;
  localparam int K_DEC_DONE = 3;
  localparam int K_TMO = 4;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic n_rst;
  logic key_ready, enc_req, dec_req, enc_busy, dec_busy;
  logic enable_encrypt, enable_decrypt, enc_grant, dec_grant;
  logic enc_done, dec_done, sched_busy, timeout_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  ev_t exp_q[$];

  aes_core_scheduler #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .key_ready(key_ready),
    .enc_req(enc_req),
    .dec_req(dec_req),
    .enc_busy(enc_busy),
    .dec_busy(dec_busy),
    .enable_encrypt(enable_encrypt),
    .enable_decrypt(enable_decrypt),
    .enc_grant(enc_grant),
    .dec_grant(dec_grant),
    .enc_done(enc_done),
    .dec_done(dec_done),
    .sched_busy(sched_busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic act, input logic want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic check_pulse(input logic v, input int kind);
    ev_t e;
    if (v === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, want none", kind, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc) begin
          bad++;
          $display("FAIL pulse_order: got kind %0d at cycle %0d, want kind %0d at cycle %0d",
                   kind, cyc, e.kind, e.cyc);
        end
      end
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    total++;
    if (enc_grant === 1'b1 && dec_grant === 1'b1) begin
      bad++;
      $display("FAIL grant_overlap: got both grants 1 at cycle %0d, want at most one", cyc);
    end
    check_pulse(enable_encrypt, K_EN_ENC);
    check_pulse(enable_decrypt, K_EN_DEC);
    check_pulse(enc_done, K_ENC_DONE);
    check_pulse(dec_done, K_DEC_DONE);
    check_pulse(timeout_err, K_TMO);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1ns after the edge that entered ISSUE. Selected core goes busy after
  // l cycles for b cycles, so DONE lands on cycle issue+l+b+1. Returns in DONE.
  task automatic job(input bit d, input int l, input int b, input bit tog);
    int x;
    x = cyc;
    push(d ? K_EN_DEC : K_EN_ENC, x);
    push(d ? K_DEC_DONE : K_ENC_DONE, x + l + b + 1);
    for (int i = 0; i < l; i++) begin
      if (tog) begin
        if (d) enc_busy = ~enc_busy; else dec_busy = ~dec_busy;
      end
      tick(1);
    end
    chk("grant_sel_wait", d ? dec_grant : enc_grant, 1'b1);
    chk("grant_other_wait", d ? enc_grant : dec_grant, 1'b0);
    if (d) dec_busy = 1'b1; else enc_busy = 1'b1;
    for (int i = 0; i < b; i++) begin
      if (tog) begin
        if (d) enc_busy = ~enc_busy; else dec_busy = ~dec_busy;
      end
      tick(1);
    end
    if (d) dec_busy = 1'b0; else enc_busy = 1'b0;
    tick(1);
    if (d) enc_busy = 1'b0; else dec_busy = 1'b0;
    chk("grant_sel_done", d ? dec_grant : enc_grant, 1'b1);
    chk("sched_busy_done", sched_busy, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en_enc"}, enable_encrypt, 1'b0);
    chk({tag, "_en_dec"}, enable_decrypt, 1'b0);
    chk({tag, "_enc_grant"}, enc_grant, 1'b0);
    chk({tag, "_dec_grant"}, dec_grant, 1'b0);
    chk({tag, "_enc_done"}, enc_done, 1'b0);
    chk({tag, "_dec_done"}, dec_done, 1'b0);
    chk({tag, "_sched_busy"}, sched_busy, 1'b0);
    chk({tag, "_timeout_err"}, timeout_err, 1'b0);
  endtask

  initial begin
    n_rst = 1'b0;
    key_ready = 1'b0;
    enc_req = 1'b0;
    dec_req = 1'b0;
    enc_busy = 1'b0;
    dec_busy = 1'b0;
    tick(2);
    chk_all_zero("reset");
    n_rst = 1'b1;
    tick(1);

    // Single encrypt job: busy 2 cycles after the enable pulse, held 10 cycles.
    key_ready = 1'b1;
    enc_req = 1'b1;
    tick(1);
    enc_req = 1'b0;
    job(1'b0, 2, 10, 1'b0);
    tick(1);
    chk("t1_idle_busy", sched_busy, 1'b0);
    chk("t1_idle_grant", enc_grant, 1'b0);

    // key_ready low holds off a decrypt request; issue follows key_ready rising.
    key_ready = 1'b0;
    dec_req = 1'b1;
    tick(20);
    chk("t2_held_busy", sched_busy, 1'b0);
    key_ready = 1'b1;
    tick(1);
    chk("t2_issue_grant", dec_grant, 1'b1);
    dec_req = 1'b0;
    job(1'b1, 2, 3, 1'b0);
    tick(1);

    // Both requesters held: last grant was dec, so enc, dec, enc, dec at 5-cycle spacing.
    enc_req = 1'b1;
    dec_req = 1'b1;
    tick(1);
    job(1'b0, 1, 1, 1'b0);
    tick(2);
    job(1'b1, 1, 1, 1'b0);
    tick(2);
    job(1'b0, 1, 1, 1'b0);
    tick(2);
    job(1'b1, 1, 1, 1'b0);
    enc_req = 1'b0;
    dec_req = 1'b0;
    tick(2);
    chk("t3_idle_busy", sched_busy, 1'b0);

    // Encrypt job with dec_busy toggling every cycle: same timing as the first job.
    enc_req = 1'b1;
    tick(1);
    enc_req = 1'b0;
    job(1'b0, 2, 10, 1'b1);
    tick(1);

    // Reset during decrypt WAIT_DONE: outputs drop at once, no done, next tie to enc.
    dec_req = 1'b1;
    tick(1);
    push(K_EN_DEC, cyc);
    dec_req = 1'b0;
    tick(1);
    dec_busy = 1'b1;
    tick(2);
    chk("t4_wd_grant", dec_grant, 1'b1);
    #2;
    n_rst = 1'b0;
    #1;
    chk_all_zero("t4_async");
    dec_busy = 1'b0;
    tick(1);
    n_rst = 1'b1;
    enc_req = 1'b1;
    dec_req = 1'b1;
    tick(1);
    job(1'b0, 1, 1, 1'b0);
    enc_req = 1'b0;
    dec_req = 1'b0;
    tick(2);

`ifdef SCHED_TIMEOUT_EN
    // dec_busy never rises: abort after 8 wait cycles, timeout_err on issue+9.
    dec_req = 1'b1;
    tick(1);
    push(K_EN_DEC, cyc);
    push(K_TMO, cyc + 9);
    dec_req = 1'b0;
    tick(9);
    chk("t5_tmo_busy", sched_busy, 1'b0);
    chk("t5_tmo_grant", dec_grant, 1'b0);
    tick(2);
`endif

    tick(3);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_events: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
